// File: rtl/gyro_pkg.sv
// Shared types for the gyro angle integrator.
// Rate/angle widths and the calibration FSM states.
package gyro_pkg;
  localparam int ANGLE_W = 16;

  typedef logic signed [15:0] rate_t;
  typedef logic signed [ANGLE_W-1:0] angle_t;

  typedef enum logic [1:0] {
    CAL_CLEAR = 2'd0,
    CALIBRATE = 2'd1,
    RUN       = 2'd2
  } gyro_state_t;
endpackage

// File: rtl/gyro_axis_integrator.sv
// One axis: bias averaging, bias subtract with saturation and
// deadband, then a wrapping fixed-point angle accumulator.
module gyro_axis_integrator
  import gyro_pkg::*;
#(
  parameter int CAL_LOG2 = 8,
  parameter int SHIFT    = 7,
  parameter int DEADBAND = 4
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   clear,
  input  logic   cal_accumulate,
  input  logic   cal_latch,
  input  logic   run_valid,
  input  rate_t  rate_in,
  output angle_t angle_out
);
  localparam int SUM_W = 16 + CAL_LOG2;
  localparam int ACC_W = ANGLE_W + SHIFT;
  localparam logic signed [16:0] DB = 17'(DEADBAND);

  logic signed [SUM_W-1:0] sum_q, sum_d, sum_inc;
  rate_t bias_q, bias_d;
  rate_t d_q, d_d, d_sat;
  logic signed [16:0] diff;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    sum_inc = sum_q + {{CAL_LOG2{rate_in[15]}}, rate_in};
    diff    = {rate_in[15], rate_in} - {bias_q[15], bias_q};

    if (diff > 17'sd32767) d_sat = 16'sh7fff;
    else if (diff < -17'sd32768) d_sat = 16'sh8000;
    else d_sat = diff[15:0];
    if ((diff <= DB) && (diff >= -DB)) d_sat = '0;

    sum_d  = cal_accumulate ? sum_inc : sum_q;
    // Upper slice of the sum is the arithmetic floor of sum / 2^CAL_LOG2
    bias_d = cal_latch ? sum_inc[CAL_LOG2+15:CAL_LOG2] : bias_q;
    d_d    = run_valid ? d_sat : '0;
    acc_d  = acc_q + {{SHIFT{d_q[15]}}, d_q};

    if (clear) begin
      sum_d  = '0;
      bias_d = '0;
      d_d    = '0;
      acc_d  = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sum_q  <= '0;
      bias_q <= '0;
      d_q    <= '0;
      acc_q  <= '0;
    end else begin
      sum_q  <= sum_d;
      bias_q <= bias_d;
      d_q    <= d_d;
      acc_q  <= acc_d;
    end
  end

  assign angle_out = acc_q[ACC_W-1:SHIFT];
endmodule

// File: rtl/gyro_angle_integrator.sv
// Gyro rate-to-angle integrator: calibration FSM, sample counter
// and valid pipeline around three per-axis integrators.
module gyro_angle_integrator
  import gyro_pkg::*;
#(
  parameter int CAL_LOG2 = 8,
  parameter int SHIFT    = 7,
  parameter int DEADBAND = 4
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   valid_in,
  input  rate_t  gx_in,
  input  rate_t  gy_in,
  input  rate_t  gz_in,
  input  logic   recal_in,
  output angle_t pitch_out,
  output angle_t roll_out,
  output angle_t yaw_out,
  output logic   valid_out,
  output logic   calibrated_out
);
  gyro_state_t state_q, state_d;
  logic [CAL_LOG2-1:0] cnt_q, cnt_d;
  logic v1_q, v1_d, v2_q, v2_d;
  logic clear, cal_acc, cal_latch, run_valid;

  always_comb begin
    clear     = recal_in | (state_q == CAL_CLEAR);
    cal_acc   = valid_in & ~recal_in & (state_q == CALIBRATE);
    cal_latch = cal_acc & (&cnt_q);
    run_valid = valid_in & ~recal_in & (state_q == RUN);

    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CAL_CLEAR: begin
        state_d = CALIBRATE;
        cnt_d   = '0;
      end
      CALIBRATE: begin
        if (cal_acc) cnt_d = cnt_q + 1'b1;
        if (cal_latch) state_d = RUN;
      end
      RUN: state_d = RUN;
      default: state_d = CAL_CLEAR;
    endcase
    if (recal_in) begin
      state_d = CAL_CLEAR;
      cnt_d   = '0;
    end

    // Recal kills whatever is still in flight
    v1_d = run_valid;
    v2_d = v1_q & ~recal_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= CAL_CLEAR;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
    end
  end

  gyro_axis_integrator #(
    .CAL_LOG2(CAL_LOG2), .SHIFT(SHIFT), .DEADBAND(DEADBAND)
  ) u_x (
    .clk_in(clk_in), .rst_in(rst_in), .clear(clear),
    .cal_accumulate(cal_acc), .cal_latch(cal_latch),
    .run_valid(run_valid), .rate_in(gx_in), .angle_out(pitch_out)
  );

  gyro_axis_integrator #(
    .CAL_LOG2(CAL_LOG2), .SHIFT(SHIFT), .DEADBAND(DEADBAND)
  ) u_y (
    .clk_in(clk_in), .rst_in(rst_in), .clear(clear),
    .cal_accumulate(cal_acc), .cal_latch(cal_latch),
    .run_valid(run_valid), .rate_in(gy_in), .angle_out(roll_out)
  );

  gyro_axis_integrator #(
    .CAL_LOG2(CAL_LOG2), .SHIFT(SHIFT), .DEADBAND(DEADBAND)
  ) u_z (
    .clk_in(clk_in), .rst_in(rst_in), .clear(clear),
    .cal_accumulate(cal_acc), .cal_latch(cal_latch),
    .run_valid(run_valid), .rate_in(gz_in), .angle_out(yaw_out)
  );

  assign valid_out      = v2_q;
  assign calibrated_out = (state_q == RUN);
endmodule
